mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the instruction-fetch and data ports onto the single variable-latency `ram` port (`cpu_ram_if` signals, `ramstate_t` status).
- Sits between the caches/datapath and `ram`.
- Holds a grant until `ram` reports ACCESS, then inserts one idle release cycle so that a repeated address restarts the RAM latency count.
- Generates the per-port wait signals and a timeout error flag.

Parameters:
- TIMEOUT, 64: maximum cycles a grant may wait for ACCESS before the grant is aborted.
- DPRIO, 1: fixed-priority winner when the optional feature is off (1 = data port, 0 = instruction port).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, synchronous, active-low. Sampled only on the CLK rising edge.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iload  out  32  instruction read data.
- iwait  out  1  instruction port stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data word address.
- dstore  in  32  data write value.
- dload  out  32  data read data.
- dwait  out  1  data port stall.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  `ramstate_t` value: FREE, BUSY, ACCESS or ERROR.
- tmo_err  out  1  sticky timeout flag.

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D, RELEASE. The state register is the only sequential arbitration state, plus a timeout counter and the tmo_err flag.
- Reset (nRST low at a rising edge):
  - state becomes IDLE, the counter clears, tmo_err clears.
  - Outputs while in IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait = iREN and dwait = dREN|dWEN: any request stalls.
  - iload and dload equal ramload.
- Reset mid-grant: the grant drops on the next edge with no ACCESS delivered. The requester stays stalled.
- IDLE:
  - No request: stay in IDLE.
  - Only one port requesting: go to that port's grant state.
  - Both ports requesting: the winner is chosen by DPRIO (or by the optional feature).
- GNT_D drive:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN; a write wins if the requester asserts both.
- GNT_I drive: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion in a grant state:
  - When ramstate==ACCESS, the granted port's wait is 0 combinationally for that cycle only. The other port's wait is 1.
  - Next state is RELEASE.
- Request withdrawn mid-grant (granted port's enables both 0): go to RELEASE with no completion.
- RELEASE:
  - ramREN=ramWEN=0 for exactly one cycle; both waits follow their requests.
  - Next state is IDLE, and arbitration restarts the cycle after.
- Latency: with RAM latency LAT, wait falls LAT+2 cycles after the request is first sampled in IDLE. Back-to-back grants are separated by 2 cycles (RELEASE, IDLE).
- Timeout counter:
  - Clears on grant entry and increments each grant cycle without ACCESS.
  - On reaching TIMEOUT-1 without ACCESS: set tmo_err, go to RELEASE, and keep the requester's wait high.
  - tmo_err clears only on reset.
- ramstate==ERROR during a grant is treated as not-ACCESS (the counter keeps running).
- Address and data are never registered: requesters hold them stable until their wait falls.

Optional Feature:
- Macro: MEMARB_RR_EN.
- Defined: a 1-bit last-winner register (reset value: instruction port was last). A simultaneous request goes to the port that did not win last; the register updates on each completed grant. DPRIO is ignored.
- Undefined: fixed priority per DPRIO, no extra register.

Decomposition:
- Add arbstate_t (IDLE, GNT_I, GNT_D, RELEASE) to `cpu_types_pkg`.
- Reuse `word_t` and `ramstate_t` from `cpu_types_pkg`.
- One natural sub-module: mem_arb_pick, the combinational winner select including the MEMARB_RR_EN logic.
- The FSM, timeout counter and muxes stay in mem_arbiter.

Test Plan:
- Data read alone, LAT=6: dREN=1, daddr=0x40, ramload=0x12345678 at ACCESS. Require dwait=0 for exactly one cycle, 8 cycles after the request is first sampled; dload=0x12345678; iwait=1 throughout if iREN is held.
- Same-address repeat: two consecutive iREN at 0x0. Require the RELEASE cycle (ramREN=0) between them, and the second completion LAT+2 cycles after its IDLE sample (not immediate).
- Simultaneous request, DPRIO=1, macro off: iREN=dWEN=1. Require the data write served first (ramWEN=1, ramstore=dstore), then the instruction read.
- MEMARB_RR_EN defined: iREN and dREN held high for 4 transactions. Require grant order D,I,D,I after reset.
- Timeout, TIMEOUT=64: ramstate forced BUSY. Require tmo_err=1 after 64 grant cycles, then RELEASE with dwait still 1; tmo_err cleared only by nRST=0.
- Synchronous reset mid-grant: nRST=0 for one edge in GNT_D. Require state IDLE and ramREN=ramWEN=0 on the following cycle, and no dwait pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: word, RAM status and arbiter state encodings.
// Pure type definitions with no timing or flow-control behaviour of their own.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_I   = 2'b01,
        GNT_D   = 2'b10,
        RELEASE = 2'b11
    } arbstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Instruction/data requester ports plus the single RAM port seen by mem_arbiter.
// master = arbiter side, slave = caches/datapath and RAM side.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      tmo_err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, tmo_err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, tmo_err
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select, zero latency; MEMARB_RR_EN swaps fixed DPRIO
// priority for alternation against the last completed winner.
module mem_arb_pick #(
    parameter int DPRIO = 1
) (
    input  logic ireq,
    input  logic dreq,
`ifdef MEMARB_RR_EN
    input  logic last_d,
`endif
    output logic pick_d
);

    always_comb begin
        pick_d = dreq;
        if (ireq && dreq) begin
`ifdef MEMARB_RR_EN
            pick_d = ~last_d;
`else
            pick_d = (DPRIO != 0);
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I/D ports onto one RAM port; wait falls LAT+2 cycles after the IDLE sample.
// Grant held until ACCESS, withdrawal or timeout, then one RELEASE cycle; MEMARB_RR_EN selects round-robin.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int DPRIO   = 1
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    arbstate_t     state;
    arbstate_t     next_state;
    logic [CW-1:0] cnt;
    logic          tmo_q;
    logic          tmo_set;
    logic          ireq;
    logic          dreq;
    logic          access;
    logic          pick_d;
    logic          ram_ren;
    logic          ram_wen;
    word_t         ram_addr;
    word_t         ram_store;
    logic          iwait_c;
    logic          dwait_c;

    assign ireq   = bus.iREN;
    assign dreq   = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == ACCESS);

`ifdef MEMARB_RR_EN
    logic last_d;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (access && state == GNT_D) begin
            last_d <= 1'b1;
        end else if (access && state == GNT_I) begin
            last_d <= 1'b0;
        end
    end
`endif

    mem_arb_pick #(.DPRIO(DPRIO)) u_pick (
        .ireq   (ireq),
        .dreq   (dreq),
`ifdef MEMARB_RR_EN
        .last_d (last_d),
`endif
        .pick_d (pick_d)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == GNT_I || state == GNT_D) begin
                if (!access && cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
            if (tmo_set) begin
                tmo_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        tmo_set    = 1'b0;
        ram_ren    = 1'b0;
        ram_wen    = 1'b0;
        ram_addr   = '0;
        ram_store  = '0;
        iwait_c    = ireq;
        dwait_c    = dreq;
        case (state)
            IDLE: begin
                if (ireq || dreq) begin
                    next_state = pick_d ? GNT_D : GNT_I;
                end
            end
            GNT_I: begin
                ram_ren  = 1'b1;
                ram_addr = bus.iaddr;
                iwait_c  = ~access;
                dwait_c  = 1'b1;
                if (access || !ireq) begin
                    next_state = RELEASE;
                end else if (cnt == CNT_MAX) begin
                    next_state = RELEASE;
                    tmo_set    = 1'b1;
                end
            end
            GNT_D: begin
                ram_wen   = bus.dWEN;
                ram_ren   = bus.dREN & ~bus.dWEN;
                ram_addr  = bus.daddr;
                ram_store = bus.dstore;
                iwait_c   = 1'b1;
                dwait_c   = ~access;
                if (access || !dreq) begin
                    next_state = RELEASE;
                end else if (cnt == CNT_MAX) begin
                    next_state = RELEASE;
                    tmo_set    = 1'b1;
                end
            end
            // Dropping the enables for a cycle restarts the RAM latency count.
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = bus.ramload;
    assign bus.dload    = bus.ramload;
    assign bus.tmo_err  = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter against a latency-6 RAM model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int LAT = 6;

    logic CLK = 1'b0;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(64), .DPRIO(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // RAM model: ACCESS after LAT+1 enabled edges, counter restarts when enables drop
    int    ram_cnt    = 0;
    logic  force_busy = 1'b0;
    word_t wr_addr    = '0;
    word_t wr_data    = '0;
    logic  ram_en;

    assign ram_en = bus.ramREN | bus.ramWEN;

    always @(posedge CLK) begin
        if (!ram_en) ram_cnt <= 0;
        else         ram_cnt <= ram_cnt + 1;
        if (bus.ramWEN && bus.ramstate == ACCESS) begin
            wr_addr <= bus.ramaddr;
            wr_data <= bus.ramstore;
        end
    end

    always_comb begin
        if (!ram_en)                                bus.ramstate = FREE;
        else if (!force_busy && ram_cnt == LAT + 1) bus.ramstate = ACCESS;
        else                                        bus.ramstate = BUSY;
        bus.ramload = 32'h0;
        if (bus.ramstate == ACCESS && bus.ramREN)
            bus.ramload = (bus.ramaddr == 32'h40) ? 32'h1234_5678 : (bus.ramaddr ^ 32'hCAFE_0000);
    end

    task automatic idle_inputs();
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN  = 1'b0; bus.daddr = '0; bus.dstore = '0;
        force_busy = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++; if (bus.ramREN !== 1'b0) begin bad++; $display("FAIL reset_ramREN got=%0b want=0", bus.ramREN); end
        total++; if (bus.ramWEN !== 1'b0) begin bad++; $display("FAIL reset_ramWEN got=%0b want=0", bus.ramWEN); end
        total++; if (bus.ramaddr !== 32'h0) begin bad++; $display("FAIL reset_ramaddr got=%h want=0", bus.ramaddr); end
        total++; if (bus.ramstore !== 32'h0) begin bad++; $display("FAIL reset_ramstore got=%h want=0", bus.ramstore); end
        total++; if (bus.tmo_err !== 1'b0) begin bad++; $display("FAIL reset_tmo_err got=%0b want=0", bus.tmo_err); end
        total++; if (bus.iwait !== 1'b0 || bus.dwait !== 1'b0) begin bad++; $display("FAIL reset_waits_idle got=%0b%0b want=00", bus.iwait, bus.dwait); end
        bus.iREN = 1'b1; bus.dWEN = 1'b1;
        #1;
        total++; if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin bad++; $display("FAIL reset_waits_req got=%0b%0b want=11", bus.iwait, bus.dwait); end
        bus.iREN = 1'b0; bus.dWEN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_data_read();
        int    fall;
        logic  iw_ok;
        word_t got;
        fall = -1; iw_ok = 1'b1; got = '0;
        bus.dREN = 1'b1; bus.daddr = 32'h40;
        bus.iREN = 1'b1; bus.iaddr = 32'h100;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.iwait !== 1'b1) iw_ok = 1'b0;
            if (bus.dwait === 1'b0) begin fall = k; got = bus.dload; break; end
        end
        total++; if (fall != LAT + 2) begin bad++; $display("FAIL dread_latency got=%0d want=%0d", fall, LAT + 2); end
        total++; if (got !== 32'h1234_5678) begin bad++; $display("FAIL dread_dload got=%h want=12345678", got); end
        @(negedge CLK);
        total++; if (bus.dwait !== 1'b1) begin bad++; $display("FAIL dread_one_cycle got=%0b want=1", bus.dwait); end
        total++; if (bus.ramREN !== 1'b0) begin bad++; $display("FAIL dread_release_ren got=%0b want=0", bus.ramREN); end
        total++; if (!iw_ok || bus.iwait !== 1'b1) begin bad++; $display("FAIL dread_iwait_held got=%0b want=1", iw_ok); end
        bus.dREN = 1'b0; bus.iREN = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_same_addr();
        int    f1, f2;
        logic  rel_ren;
        word_t got;
        f1 = -1; f2 = -1; rel_ren = 1'bx; got = '0;
        bus.iREN = 1'b1; bus.iaddr = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == LAT + 3) rel_ren = bus.ramREN;
            if (bus.iwait === 1'b0) begin
                if (f1 < 0) begin f1 = k; got = bus.iload; end
                else begin f2 = k; break; end
            end
        end
        total++; if (f1 != LAT + 2) begin bad++; $display("FAIL repeat_first got=%0d want=%0d", f1, LAT + 2); end
        total++; if (got !== 32'hCAFE_0000) begin bad++; $display("FAIL repeat_iload got=%h want=cafe0000", got); end
        total++; if (rel_ren !== 1'b0) begin bad++; $display("FAIL repeat_release_ren got=%0b want=0", rel_ren); end
        total++; if (f2 != 2 * LAT + 6) begin bad++; $display("FAIL repeat_second got=%0d want=%0d", f2, 2 * LAT + 6); end
        @(negedge CLK);
        bus.iREN = 1'b0;
        @(negedge CLK);
    endtask

`ifndef MEMARB_RR_EN
    task automatic test_fixed_priority();
        int    df, ifl;
        word_t got;
        df = -1; ifl = -1; got = '0;
        bus.iREN = 1'b1; bus.iaddr = 32'h8;
        bus.dWEN = 1'b1; bus.daddr = 32'h20; bus.dstore = 32'hDEAD_BEEF;
        @(negedge CLK);
        total++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin bad++; $display("FAIL prio_d_enables got=%0b%0b want=10", bus.ramWEN, bus.ramREN); end
        total++; if (bus.ramaddr !== 32'h20) begin bad++; $display("FAIL prio_d_addr got=%h want=20", bus.ramaddr); end
        total++; if (bus.ramstore !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_d_store got=%h want=deadbeef", bus.ramstore); end
        for (int k = 2; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.dwait === 1'b0) begin df = k; break; end
        end
        total++; if (df != LAT + 2) begin bad++; $display("FAIL prio_d_done got=%0d want=%0d", df, LAT + 2); end
        @(negedge CLK);
        bus.dWEN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        total++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h8 || bus.ramstore !== 32'h0) begin
            bad++; $display("FAIL prio_i_drive got=%0b%0b %h %h want=10 8 0", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
        end
        for (int k = 12; k <= 30; k++) begin
            @(negedge CLK);
            if (bus.iwait === 1'b0) begin ifl = k; got = bus.iload; break; end
        end
        total++; if (ifl != 2 * LAT + 6) begin bad++; $display("FAIL prio_i_done got=%0d want=%0d", ifl, 2 * LAT + 6); end
        total++; if (got !== 32'hCAFE_0008) begin bad++; $display("FAIL prio_i_iload got=%h want=cafe0008", got); end
        total++; if (wr_addr !== 32'h20 || wr_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_write got=%h/%h want=20/deadbeef", wr_addr, wr_data); end
        @(negedge CLK);
        bus.iREN = 1'b0;
        @(negedge CLK);
    endtask
`else
    task automatic test_round_robin();
        string order;
        order = "";
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        bus.iREN = 1'b1; bus.iaddr = 32'h4;
        bus.dREN = 1'b1; bus.daddr = 32'h44;
        for (int k = 1; k <= 80 && order.len() < 4; k++) begin
            @(negedge CLK);
            if (bus.dwait === 1'b0) order = {order, "D"};
            if (bus.iwait === 1'b0) order = {order, "I"};
        end
        total++; if (order != "DIDI") begin bad++; $display("FAIL rr_order got=%s want=DIDI", order); end
        @(negedge CLK);
        bus.iREN = 1'b0; bus.dREN = 1'b0;
        @(negedge CLK);
    endtask
`endif

    task automatic test_timeout();
        logic dw_ok;
        logic tmo64;
        dw_ok = 1'b1; tmo64 = 1'bx;
        force_busy = 1'b1;
        bus.dREN = 1'b1; bus.daddr = 32'h80;
        for (int k = 1; k <= 64; k++) begin
            @(negedge CLK);
            if (bus.dwait !== 1'b1) dw_ok = 1'b0;
            if (k == 64) tmo64 = bus.tmo_err;
        end
        total++; if (tmo64 !== 1'b0) begin bad++; $display("FAIL tmo_early got=%0b want=0", tmo64); end
        @(negedge CLK);
        total++; if (bus.tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_set got=%0b want=1", bus.tmo_err); end
        total++; if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin bad++; $display("FAIL tmo_release got=ren%0b dwait%0b want=ren0 dwait1", bus.ramREN, bus.dwait); end
        total++; if (!dw_ok) begin bad++; $display("FAIL tmo_dwait_held got=0 want=1"); end
        bus.dREN = 1'b0; force_busy = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (bus.tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%0b want=1", bus.tmo_err); end
        nRST = 1'b0;
        @(negedge CLK);
        total++; if (bus.tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%0b want=0", bus.tmo_err); end
        nRST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_grant();
        logic dw_ok;
        int   fall;
        dw_ok = 1'b1; fall = -1;
        bus.dREN = 1'b1; bus.daddr = 32'h40;
        repeat (3) begin
            @(negedge CLK);
            if (bus.dwait !== 1'b1) dw_ok = 1'b0;
        end
        total++; if (bus.ramREN !== 1'b1) begin bad++; $display("FAIL midrst_granted got=%0b want=1", bus.ramREN); end
        nRST = 1'b0;
        @(negedge CLK);
        total++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%0b%0b want=00", bus.ramREN, bus.ramWEN); end
        total++; if (!dw_ok || bus.dwait !== 1'b1) begin bad++; $display("FAIL midrst_no_pulse got=%0b want=1", bus.dwait); end
        nRST = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (bus.dwait === 1'b0) begin fall = k; break; end
        end
        total++; if (fall != LAT + 2) begin bad++; $display("FAIL midrst_regrant got=%0d want=%0d", fall, LAT + 2); end
        @(negedge CLK);
        bus.dREN = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_data_read();
        test_same_addr();
`ifndef MEMARB_RR_EN
        test_fixed_priority();
`else
        test_round_robin();
`endif
        test_timeout();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
